// File: rtl/countdown_timer_if.sv
// Load handshake bundle for countdown_timer.
// Requester drives valid/value/mode; timer drives ready.
interface countdown_timer_if #(
    parameter int WIDTH = 4
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_value;
    logic             periodic;

    modport master (
        output load_valid,
        output load_value,
        output periodic,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_value,
        input  periodic,
        output load_ready
    );
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter with one-shot or auto-reload mode.
// Expire is a registered one-cycle pulse on terminal count.
module countdown_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             abort,
    countdown_timer_if.slave ld,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             expire
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] reload;
    logic             mode;
    logic             accept;

    assign ld.load_ready = (state == IDLE) && !abort;
    assign accept        = ld.load_valid && ld.load_ready;
    assign busy          = (state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            count  <= '0;
            reload <= '0;
            mode   <= 1'b0;
            expire <= 1'b0;
        end else begin
            expire <= 1'b0;
            if (abort) begin
                // reload/mode survive an abort
                state <= IDLE;
                count <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (accept) begin
                            if (ld.load_value != '0) begin
                                count  <= ld.load_value;
                                reload <= ld.load_value;
                                mode   <= ld.periodic;
                                state  <= RUN;
                            end else begin
                                count  <= '0;
                                expire <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        if (enable) begin
                            if (count == WIDTH'(1)) begin
                                expire <= 1'b1;
                                if (mode) begin
                                    count <= reload;
                                end else begin
                                    count <= '0;
                                    state <= IDLE;
                                end
                            end else begin
                                count <= count - WIDTH'(1);
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_countdown_timer.sv
// Directed vector bench for countdown_timer.
// Table of per-cycle stimulus/expectation plus hand-written corner sequences.
module tb_countdown_timer;
    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       abort;
    logic [3:0] count;
    logic       busy;
    logic       expire;

    int n_vec;
    int n_bad;

    countdown_timer_if #(.WIDTH(4)) ld ();

    countdown_timer #(.WIDTH(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .abort  (abort),
        .ld     (ld),
        .count  (count),
        .busy   (busy),
        .expire (expire)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       ab;
        logic       lv;
        logic [3:0] val;
        logic       per;
        logic [3:0] cnt;
        logic       bsy;
        logic       exp;
        logic       rdy;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic en, input logic ab, input logic lv,
                       input logic [3:0] val, input logic per,
                       input logic [3:0] cnt, input logic bsy,
                       input logic exp, input logic rdy);
        vec_t v;
        v.en = en; v.ab = ab; v.lv = lv; v.val = val; v.per = per;
        v.cnt = cnt; v.bsy = bsy; v.exp = exp; v.rdy = rdy;
        tv.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)",
                     name, act, req, $time);
        end
    endtask

    initial begin
        int cyc;
        int seen;
        n_vec = 0;
        n_bad = 0;
        rst_n = 1'b0;
        enable = 1'b0;
        abort = 1'b0;
        ld.load_valid = 1'b0;
        ld.load_value = 4'd0;
        ld.periodic = 1'b0;

        //      en ab lv val per   cnt bsy exp rdy
        // one-shot 3
        add(1, 0, 1, 4'd3, 0,  4'd3, 1, 0, 0);
        add(1, 0, 0, 4'd0, 0,  4'd2, 1, 0, 0);
        add(1, 0, 0, 4'd0, 0,  4'd1, 1, 0, 0);
        add(1, 0, 0, 4'd0, 0,  4'd0, 0, 1, 1);
        add(1, 0, 0, 4'd0, 0,  4'd0, 0, 0, 1);
        // periodic 2
        add(1, 0, 1, 4'd2, 1,  4'd2, 1, 0, 0);
        add(1, 0, 0, 4'd0, 0,  4'd1, 1, 0, 0);
        add(1, 0, 0, 4'd0, 0,  4'd2, 1, 1, 0);
        add(1, 0, 0, 4'd0, 0,  4'd1, 1, 0, 0);
        add(1, 0, 0, 4'd0, 0,  4'd2, 1, 1, 0);
        add(1, 0, 0, 4'd0, 0,  4'd1, 1, 0, 0);
        add(1, 0, 0, 4'd0, 0,  4'd2, 1, 1, 0);
        add(1, 1, 0, 4'd0, 0,  4'd0, 0, 0, 0);
        add(0, 0, 0, 4'd0, 0,  4'd0, 0, 0, 1);
        // enable gating, then load ignored while running
        add(0, 0, 1, 4'd4, 0,  4'd4, 1, 0, 0);
        add(1, 0, 0, 4'd0, 0,  4'd3, 1, 0, 0);
        add(0, 0, 0, 4'd0, 0,  4'd3, 1, 0, 0);
        add(0, 0, 0, 4'd0, 0,  4'd3, 1, 0, 0);
        add(1, 0, 0, 4'd0, 0,  4'd2, 1, 0, 0);
        add(0, 0, 1, 4'd9, 1,  4'd2, 1, 0, 0);
        add(1, 0, 1, 4'd9, 1,  4'd1, 1, 0, 0);
        add(1, 0, 0, 4'd0, 0,  4'd0, 0, 1, 1);
        // abort beats load in IDLE
        add(0, 1, 1, 4'd5, 0,  4'd0, 0, 0, 0);
        add(0, 0, 0, 4'd0, 0,  4'd0, 0, 0, 1);
        // abort at count 5 while running
        add(0, 0, 1, 4'd5, 1,  4'd5, 1, 0, 0);
        add(1, 1, 0, 4'd0, 0,  4'd0, 0, 0, 0);
        add(1, 0, 0, 4'd0, 0,  4'd0, 0, 0, 1);
        // zero load
        add(1, 0, 1, 4'd0, 0,  4'd0, 0, 1, 1);
        add(1, 0, 0, 4'd0, 0,  4'd0, 0, 0, 1);
        // periodic reload 1: expire every cycle
        add(0, 0, 1, 4'd1, 1,  4'd1, 1, 0, 0);
        add(1, 0, 0, 4'd0, 0,  4'd1, 1, 1, 0);
        add(1, 0, 0, 4'd0, 0,  4'd1, 1, 1, 0);
        add(1, 1, 0, 4'd0, 0,  4'd0, 0, 0, 0);
        add(0, 0, 0, 4'd0, 0,  4'd0, 0, 0, 1);

        #12;
        check("rst_count", count, 0);
        check("rst_busy", busy, 0);
        check("rst_expire", expire, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_ready", ld.load_ready, 1);

        foreach (tv[i]) begin
            @(negedge clk);
            enable = tv[i].en;
            abort = tv[i].ab;
            ld.load_valid = tv[i].lv;
            ld.load_value = tv[i].val;
            ld.periodic = tv[i].per;
            @(posedge clk);
            #1;
            check($sformatf("v%0d_count", i), count, tv[i].cnt);
            check($sformatf("v%0d_busy", i), busy, tv[i].bsy);
            check($sformatf("v%0d_expire", i), expire, tv[i].exp);
            check($sformatf("v%0d_ready", i), ld.load_ready, tv[i].rdy);
        end

        // max value: expire exactly 15 enabled cycles after load
        @(negedge clk);
        enable = 1'b1;
        abort = 1'b0;
        ld.load_valid = 1'b1;
        ld.load_value = 4'd15;
        ld.periodic = 1'b0;
        @(posedge clk);
        #1;
        ld.load_valid = 1'b0;
        check("max_load", count, 15);
        seen = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (expire) begin
                seen = k;
                break;
            end
        end
        check("max_cycles", seen, 15);
        check("max_count0", count, 0);

        // async reset mid-run at count 7
        @(negedge clk);
        ld.load_valid = 1'b1;
        ld.load_value = 4'd9;
        @(posedge clk);
        #1;
        ld.load_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("ar_count7", count, 7);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_count", count, 0);
        check("ar_busy", busy, 0);
        check("ar_expire", expire, 0);
        @(posedge clk);
        #1;
        check("ar_expire_hold", expire, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ar_ready", ld.load_ready, 1);
        cyc = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (expire) cyc++;
        end
        check("ar_no_expire", cyc, 0);
        check("ar_idle_count", count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
